// File: rtl/bp_fe_icache_data_fill.sv
// I-cache data-array fill sequencer: buffers one full-block fill packet and
// streams it into the banked data array one bank word per granted cycle.
module bp_fe_icache_data_fill #(
  parameter int lce_sets_p       = 64,
  parameter int ways_p           = 8,
  parameter int lce_data_width_p = 512,
  parameter int data_width_p     = 64,
  localparam int lg_lce_sets_lp  = $clog2(lce_sets_p),
  localparam int lg_ways_lp      = $clog2(ways_p),
  localparam int num_banks_lp    = lce_data_width_p / data_width_p,
  localparam int lg_banks_lp     = $clog2(num_banks_lp),
  localparam int pkt_width_lp    = lg_lce_sets_lp + lg_ways_lp + lce_data_width_p + 1
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [pkt_width_lp-1:0]   data_mem_pkt_i,
  input  logic                      data_mem_pkt_v_i,
  output logic                      data_mem_pkt_yumi_o,
  output logic                      data_mem_v_o,
  output logic [lg_lce_sets_lp-1:0] data_mem_index_o,
  output logic [lg_ways_lp-1:0]     data_mem_way_o,
  output logic [lg_banks_lp-1:0]    data_mem_bank_o,
  output logic [data_width_p-1:0]   data_mem_data_o,
  input  logic                      data_mem_yumi_i,
  output logic                      fill_done_o,
  output logic                      busy_o,
  output logic [lg_lce_sets_lp-1:0] busy_index_o,
  output logic [lg_ways_lp-1:0]     busy_way_o
);

  typedef enum logic {IDLE, WRITE} state_e;

  state_e                                   state;
  logic [lg_banks_lp-1:0]                   cnt;
  logic [num_banks_lp-1:0][data_width_p-1:0] blk;
  logic [lg_lce_sets_lp-1:0]                idx_r;
  logic [lg_ways_lp-1:0]                    way_r;

  logic                        pkt_we;
  logic [lce_data_width_p-1:0] pkt_data;
  logic [lg_ways_lp-1:0]       pkt_way;
  logic [lg_lce_sets_lp-1:0]   pkt_index;
  logic                        last_write;
  logic                        load;

  assign pkt_we    = data_mem_pkt_i[0];
  assign pkt_data  = data_mem_pkt_i[lce_data_width_p:1];
  assign pkt_way   = data_mem_pkt_i[lce_data_width_p+1 +: lg_ways_lp];
  assign pkt_index = data_mem_pkt_i[lce_data_width_p+1+lg_ways_lp +: lg_lce_sets_lp];

  assign last_write = (state == WRITE) && data_mem_yumi_i
                      && (cnt == lg_banks_lp'(num_banks_lp - 1));

  // Accepting on the last granted write lets the next block start with no bubble.
  assign data_mem_pkt_yumi_o = reset_n_i && data_mem_pkt_v_i
                               && ((state == IDLE) || last_write);
  assign load = data_mem_pkt_yumi_o && pkt_we;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
      cnt   <= '0;
      blk   <= '0;
      idx_r <= '0;
      way_r <= '0;
    end else if (load) begin
      state <= WRITE;
      cnt   <= '0;
      blk   <= pkt_data;
      idx_r <= pkt_index;
      way_r <= pkt_way;
    end else if (last_write) begin
      // Clearing the buffer on exit keeps every write output at zero while idle.
      state <= IDLE;
      cnt   <= '0;
      blk   <= '0;
      idx_r <= '0;
      way_r <= '0;
    end else if ((state == WRITE) && data_mem_yumi_i) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign data_mem_v_o     = (state == WRITE);
  assign data_mem_index_o = idx_r;
  assign data_mem_way_o   = way_r;
  assign data_mem_bank_o  = cnt;
  assign data_mem_data_o  = blk[cnt];
  assign fill_done_o      = last_write;
  assign busy_o           = (state == WRITE);
  assign busy_index_o     = idx_r;
  assign busy_way_o       = way_r;

endmodule

// File: tb/tb_bp_fe_icache_data_fill.sv
// Directed bench for bp_fe_icache_data_fill: queue-based write model checked
// every cycle, plus literal cycle/data expectations per scenario.
module tb_bp_fe_icache_data_fill;

  logic             clk;
  logic             reset_n;
  logic [5:0]       p_idx;
  logic [2:0]       p_way;
  logic             p_we;
  logic [7:0][63:0] p_data;
  logic [521:0]     pkt;
  logic             pkt_v;
  logic             pkt_yumi;
  logic             wv;
  logic [5:0]       widx;
  logic [2:0]       wway;
  logic [2:0]       wbank;
  logic [63:0]      wdata;
  logic             gnt;
  logic             done;
  logic             busy;
  logic [5:0]       bidx;
  logic [2:0]       bway;

  assign pkt = {p_idx, p_way, p_data, p_we};

  bp_fe_icache_data_fill dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .data_mem_pkt_i(pkt), .data_mem_pkt_v_i(pkt_v), .data_mem_pkt_yumi_o(pkt_yumi),
    .data_mem_v_o(wv), .data_mem_index_o(widx), .data_mem_way_o(wway),
    .data_mem_bank_o(wbank), .data_mem_data_o(wdata), .data_mem_yumi_i(gnt),
    .fill_done_o(done), .busy_o(busy), .busy_index_o(bidx), .busy_way_o(bway)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int rc    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [5:0]  idx;
    logic [2:0]  way;
    logic [2:0]  bank;
    logic [63:0] data;
    bit          last;
  } wr_t;

  // Model: an accepted block becomes eight pending writes; a grant retires the head.
  wr_t q[$];
  wr_t wlog[$];
  int  yumi_q[$];
  int  done_q[$];
  int  busy_n;

  logic        ex_v, ex_done, ex_yumi;
  logic [5:0]  ex_idx;
  logic [2:0]  ex_way, ex_bank;
  logic [63:0] ex_data;

  always @(negedge clk) begin
    ex_v = 0; ex_done = 0; ex_yumi = 0;
    ex_idx = '0; ex_way = '0; ex_bank = '0; ex_data = '0;
    if (!reset_n) begin
      q.delete();
    end else begin
      ex_v = (q.size() > 0);
      if (ex_v) begin
        ex_idx = q[0].idx; ex_way = q[0].way; ex_bank = q[0].bank; ex_data = q[0].data;
        ex_done = gnt && q[0].last;
      end
      ex_yumi = pkt_v && (!ex_v || ex_done);
    end
    chk("yumi", pkt_yumi, ex_yumi);
    chk("wr_v", wv, ex_v);
    chk("wr_index", widx, ex_idx);
    chk("wr_way", wway, ex_way);
    chk("wr_bank", wbank, ex_bank);
    chk("wr_data", wdata, ex_data);
    chk("fill_done", done, ex_done);
    chk("busy", busy, ex_v);
    chk("busy_index", bidx, ex_idx);
    chk("busy_way", bway, ex_way);
    if (pkt_yumi) yumi_q.push_back(rc);
    if (done) done_q.push_back(rc);
    if (busy) busy_n++;
    if (wv && gnt) begin
      wr_t w;
      w.cyc = rc; w.idx = widx; w.way = wway; w.bank = wbank; w.data = wdata; w.last = 0;
      wlog.push_back(w);
    end
    if (reset_n) begin
      if (ex_v && gnt) void'(q.pop_front());
      if (ex_yumi && p_we) begin
        for (int k = 0; k < 8; k++) begin
          wr_t e;
          e.cyc = 0; e.idx = p_idx; e.way = p_way; e.bank = 3'(k);
          e.data = p_data[k]; e.last = (k == 7);
          q.push_back(e);
        end
      end
    end
  end

  function automatic int qget(input int qq[$], input int i);
    return (i < qq.size()) ? qq[i] : -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    rc++;
  endtask

  task automatic clear_logs();
    rc = 0;
    wlog.delete(); yumi_q.delete(); done_q.delete(); busy_n = 0;
  endtask

  task automatic set_pkt(input logic [5:0] idx, input logic [2:0] way, input logic we, input int pat);
    p_idx = idx; p_way = way; p_we = we;
    for (int k = 0; k < 8; k++)
      case (pat)
        0:       p_data[k] = 64'h1111_1111_1111_1111 * k;
        1:       p_data[k] = 64'hB0B0_0000_0000_0000 | 64'(k);
        default: p_data[k] = 64'hC000_0000_0000_0000 + 64'(k);
      endcase
  endtask

  // Packet A at cycle 0; optional packet B offered from cycle 1 until consumed.
  task automatic run_test(input int ncyc, input logic [5:0] aidx, input logic [2:0] away,
                          input logic awe, input bit has_b, input int d0, input int d1);
    for (int c = 0; c < ncyc; c++) begin
      tick();
      if (c == 0) clear_logs();
      gnt = !((c == d0) || (c == d1));
      if (c == 0) begin
        set_pkt(aidx, away, awe, 0); pkt_v = 1;
      end else if (has_b && yumi_q.size() < 2) begin
        set_pkt(6'd6, 3'd0, 1'b1, 1); pkt_v = 1;
      end else begin
        pkt_v = 0;
      end
    end
  endtask

  initial begin
    clk = 0; reset_n = 0; pkt_v = 0; gnt = 0;
    set_pkt(6'd0, 3'd0, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    tick();

    // Single fill, continuous grants
    run_test(12, 6'd5, 3'd3, 1'b1, 0, -1, -1);
    chk("t1_yumi_cyc", qget(yumi_q, 0), 0);
    chk("t1_yumi_n", yumi_q.size(), 1);
    chk("t1_done_cyc", qget(done_q, 0), 8);
    chk("t1_done_n", done_q.size(), 1);
    chk("t1_writes", wlog.size(), 8);
    chk("t1_busy_n", busy_n, 8);
    if (wlog.size() == 8) begin
      chk("t1_w0_cyc", wlog[0].cyc, 1);
      chk("t1_w0_idx", wlog[0].idx, 5);
      chk("t1_w0_way", wlog[0].way, 3);
      chk("t1_w3_data", wlog[3].data, 64'h3333_3333_3333_3333);
      chk("t1_w7_bank", wlog[7].bank, 7);
      chk("t1_w7_data", wlog[7].data, 64'h7777_7777_7777_7777);
    end

    // Grant denied in cycles 2 and 5
    run_test(14, 6'd5, 3'd3, 1'b1, 0, 2, 5);
    chk("t2_done_cyc", qget(done_q, 0), 10);
    chk("t2_writes", wlog.size(), 8);
    chk("t2_busy_n", busy_n, 10);
    for (int k = 0; k < 8; k++)
      if (k < wlog.size()) chk("t2_bank_order", wlog[k].bank, k);

    // Back-to-back fills
    run_test(20, 6'd5, 3'd3, 1'b1, 1, -1, -1);
    chk("t3_yumi0", qget(yumi_q, 0), 0);
    chk("t3_yumi1", qget(yumi_q, 1), 8);
    chk("t3_done0", qget(done_q, 0), 8);
    chk("t3_done1", qget(done_q, 1), 16);
    chk("t3_writes", wlog.size(), 16);
    if (wlog.size() == 16) begin
      chk("t3_b0_cyc", wlog[8].cyc, 9);
      chk("t3_b0_idx", wlog[8].idx, 6);
      chk("t3_b0_bank", wlog[8].bank, 0);
      chk("t3_b5_data", wlog[13].data, 64'hB0B0_0000_0000_0005);
    end

    // we=0 packet is dropped
    run_test(5, 6'd12, 3'd1, 1'b0, 0, -1, -1);
    chk("t4_yumi_cyc", qget(yumi_q, 0), 0);
    chk("t4_yumi_n", yumi_q.size(), 1);
    chk("t4_writes", wlog.size(), 0);
    chk("t4_done_n", done_q.size(), 0);
    chk("t4_busy_n", busy_n, 0);

    // Reset in the middle of a fill, then a fresh fill
    for (int c = 0; c < 22; c++) begin
      tick();
      if (c == 0) clear_logs();
      gnt = 1;
      pkt_v = 0;
      if (c == 0) begin set_pkt(6'd5, 3'd3, 1'b1, 0); pkt_v = 1; end
      if (c == 5) reset_n = 0;
      if (c == 7) reset_n = 1;
      if (c == 10) begin set_pkt(6'd9, 3'd7, 1'b1, 2); pkt_v = 1; end
    end
    chk("t5_yumi0", qget(yumi_q, 0), 0);
    chk("t5_yumi1", qget(yumi_q, 1), 10);
    chk("t5_done_n", done_q.size(), 1);
    chk("t5_done_cyc", qget(done_q, 0), 18);
    chk("t5_writes", wlog.size(), 12);
    if (wlog.size() == 12) begin
      chk("t5_pre_last_bank", wlog[3].bank, 3);
      chk("t5_pre_last_cyc", wlog[3].cyc, 4);
      chk("t5_new_cyc", wlog[4].cyc, 11);
      chk("t5_new_bank", wlog[4].bank, 0);
      chk("t5_new_idx", wlog[4].idx, 9);
      chk("t5_new_data", wlog[4].data, 64'hC000_0000_0000_0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
